// File: rtl/gps_wb_pkg.sv
// Shared definitions for the GPS channel register file: offsets, status bits, field slices.
package gps_wb_pkg;

  // Byte offsets within the channel's 256-byte page
  localparam logic [7:0] REG_CODE_FREQ  = 8'h00;
  localparam logic [7:0] REG_CARR_FREQ  = 8'h04;
  localparam logic [7:0] REG_CODE_OFF   = 8'h08;
  localparam logic [7:0] REG_CARR_OFF   = 8'h0C;
  localparam logic [7:0] REG_ACQ_THRESH = 8'h10;
  localparam logic [7:0] REG_CONFIG     = 8'h14;
  localparam logic [7:0] REG_SNAP_IP    = 8'h18;
  localparam logic [7:0] REG_SNAP_QP    = 8'h1C;
  localparam logic [7:0] REG_SNAP_IL    = 8'h20;
  localparam logic [7:0] REG_SNAP_QL    = 8'h24;
  localparam logic [7:0] REG_SNAP_IE    = 8'h28;
  localparam logic [7:0] REG_SNAP_QE    = 8'h2C;
  localparam logic [7:0] REG_STATUS     = 8'h30;

  // The read/write registers occupy word indices 0..NUM_RW_REGS-1
  localparam int unsigned NUM_RW_REGS = 6;

  // STATUS bit positions
  localparam int unsigned ST_READY = 0;
  localparam int unsigned ST_OVR   = 1;
  localparam int unsigned ST_LOCK  = 2;

  // Satellite id field inside CONFIG
  localparam int unsigned SAT_ID_MSB = 31;
  localparam int unsigned SAT_ID_LSB = 24;

  // Snapshot FSM encoding
  localparam logic [0:0] SNAP_EMPTY = 1'b0;
  localparam logic [0:0] SNAP_FULL  = 1'b1;

  // One set of correlator accumulators
  typedef struct packed {
    logic [31:0] ip;
    logic [31:0] qp;
    logic [31:0] il;
    logic [31:0] ql;
    logic [31:0] ie;
    logic [31:0] qe;
  } acc_set_t;

  function automatic logic [7:0] cfg_sat_id(input logic [31:0] cfg);
    return cfg[SAT_ID_MSB:SAT_ID_LSB];
  endfunction

  // Merge write data into an existing word under byte enables
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gps_acc_snapshot.sv
// Accumulator snapshot holder: captures one dump, then holds it until software clears ready.
module gps_acc_snapshot
  import gps_wb_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     dump_i,
  input  logic     clr_ready_i,
  input  logic     clr_ovr_i,
  input  acc_set_t acc_i,
  output acc_set_t snap_o,
  output logic     ready_o,
  output logic     ovr_o
);

  logic [0:0] state_q, state_d, state_eff;
  acc_set_t   snap_q, snap_d;
  logic       ovr_q, ovr_d;

  // Clear is applied before the dump, so a same-edge clear+dump recaptures
  always_comb begin
    state_eff = clr_ready_i ? SNAP_EMPTY : state_q;
    state_d   = state_eff;
    snap_d    = snap_q;
    ovr_d     = ovr_q & ~clr_ovr_i;
    if (dump_i) begin
      if (state_eff == SNAP_EMPTY) begin
        snap_d  = acc_i;
        state_d = SNAP_FULL;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State, shadow registers and sticky overrun
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SNAP_EMPTY;
      snap_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ovr_q   <= ovr_d;
    end
  end

  assign snap_o  = snap_q;
  assign ready_o = (state_q == SNAP_FULL);
  assign ovr_o   = ovr_q;

endmodule

// File: rtl/gps_channel_wb_slave.sv
// Wishbone classic slave holding one GPS tracking channel's control and observation registers.
module gps_channel_wb_slave #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = 'h0000_0A00
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  input  logic          dump_i,
  input  logic [31:0]   acc_ip_i,
  input  logic [31:0]   acc_qp_i,
  input  logic [31:0]   acc_ie_i,
  input  logic [31:0]   acc_qe_i,
  input  logic [31:0]   acc_il_i,
  input  logic [31:0]   acc_ql_i,
  input  logic          lock_i,
  output logic [31:0]   code_freq_o,
  output logic [31:0]   carr_freq_o,
  output logic [31:0]   code_off_o,
  output logic [31:0]   carr_off_o,
  output logic [31:0]   acq_thresh_o,
  output logic [31:0]   cfg_o,
  output logic          freq_wr_o,
  output logic [7:0]    sat_id_o
);

  import gps_wb_pkg::*;

  logic          sel, wr;
  logic [7:0]    off;
  logic          ack_q;
  logic [DW-1:0] dat_q, rdata;
  logic          freq_wr_q, freq_wr_d;
  logic [31:0]   rw_q [NUM_RW_REGS];
  logic [31:0]   rw_d [NUM_RW_REGS];
  logic          clr_ready, clr_ovr;
  logic          ready, ovr;
  acc_set_t      acc, snap;
  logic          unused_adr;

  // Byte lanes inside a word are not decoded
  assign unused_adr = ^wb_adr_i[1:0];

  assign off = {wb_adr_i[7:2], 2'b00};
  // Masking with ack_q spaces back-to-back acks one idle cycle apart
  assign sel = wb_stb_i & wb_cyc_i & (wb_adr_i[AW-1:8] == BASE_ADDR[AW-1:8]) & ~ack_q;
  assign wr  = sel & wb_we_i;

  // STATUS bits are write-zero-to-clear, only through byte lane 0
  assign clr_ready = wr & (off == REG_STATUS) & wb_sel_i[0] & ~wb_dat_i[ST_READY];
  assign clr_ovr   = wr & (off == REG_STATUS) & wb_sel_i[0] & ~wb_dat_i[ST_OVR];

  assign freq_wr_d = wr & (off <= REG_CARR_OFF);

  assign acc.ip = acc_ip_i;
  assign acc.qp = acc_qp_i;
  assign acc.il = acc_il_i;
  assign acc.ql = acc_ql_i;
  assign acc.ie = acc_ie_i;
  assign acc.qe = acc_qe_i;

  gps_acc_snapshot u_snapshot (
    .clk_i       (wb_clk_i),
    .rst_ni      (wb_rst_i),
    .dump_i      (dump_i),
    .clr_ready_i (clr_ready),
    .clr_ovr_i   (clr_ovr),
    .acc_i       (acc),
    .snap_o      (snap),
    .ready_o     (ready),
    .ovr_o       (ovr)
  );

  // Byte-enabled write into the read/write registers
  always_comb begin
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      rw_d[i] = rw_q[i];
      if (wr && (off == 8'(4 * i))) rw_d[i] = apply_be(rw_q[i], wb_dat_i, wb_sel_i);
    end
  end

  // Read mux over pre-update state; unmapped offsets return zero
  always_comb begin
    rdata = '0;
    case (off)
      REG_CODE_FREQ:  rdata = rw_q[0];
      REG_CARR_FREQ:  rdata = rw_q[1];
      REG_CODE_OFF:   rdata = rw_q[2];
      REG_CARR_OFF:   rdata = rw_q[3];
      REG_ACQ_THRESH: rdata = rw_q[4];
      REG_CONFIG:     rdata = rw_q[5];
      REG_SNAP_IP:    rdata = snap.ip;
      REG_SNAP_QP:    rdata = snap.qp;
      REG_SNAP_IL:    rdata = snap.il;
      REG_SNAP_QL:    rdata = snap.ql;
      REG_SNAP_IE:    rdata = snap.ie;
      REG_SNAP_QE:    rdata = snap.qe;
      REG_STATUS: begin
        rdata[ST_READY] = ready;
        rdata[ST_OVR]   = ovr;
        rdata[ST_LOCK]  = lock_i;
      end
      default: rdata = '0;
    endcase
  end

  // Bus handshake, read data and register state
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      freq_wr_q <= 1'b0;
      for (int i = 0; i < NUM_RW_REGS; i++) rw_q[i] <= '0;
    end else begin
      ack_q     <= sel;
      dat_q     <= sel ? rdata : '0;
      freq_wr_q <= freq_wr_d;
      for (int i = 0; i < NUM_RW_REGS; i++) rw_q[i] <= rw_d[i];
    end
  end

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;
  assign freq_wr_o    = freq_wr_q;
  assign code_freq_o  = rw_q[0];
  assign carr_freq_o  = rw_q[1];
  assign code_off_o   = rw_q[2];
  assign carr_off_o   = rw_q[3];
  assign acq_thresh_o = rw_q[4];
  assign cfg_o        = rw_q[5];
  assign sat_id_o     = cfg_sat_id(rw_q[5]);

endmodule

// File: tb/tb_gps_channel_wb_slave.sv
// Self-checking bench for the GPS channel Wishbone register file.
module tb_gps_channel_wb_slave;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        dump_i;
  logic [31:0] acc_ip_i, acc_qp_i, acc_ie_i, acc_qe_i, acc_il_i, acc_ql_i;
  logic        lock_i;
  logic [31:0] code_freq_o, carr_freq_o, code_off_o, carr_off_o, acq_thresh_o, cfg_o;
  logic        freq_wr_o;
  logic [7:0]  sat_id_o;

  always #5 wb_clk_i = ~wb_clk_i;

  gps_channel_wb_slave dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_i     (wb_sel_i),
    .wb_we_i      (wb_we_i),
    .wb_stb_i     (wb_stb_i),
    .wb_cyc_i     (wb_cyc_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .dump_i       (dump_i),
    .acc_ip_i     (acc_ip_i),
    .acc_qp_i     (acc_qp_i),
    .acc_ie_i     (acc_ie_i),
    .acc_qe_i     (acc_qe_i),
    .acc_il_i     (acc_il_i),
    .acc_ql_i     (acc_ql_i),
    .lock_i       (lock_i),
    .code_freq_o  (code_freq_o),
    .carr_freq_o  (carr_freq_o),
    .code_off_o   (code_off_o),
    .carr_off_o   (carr_off_o),
    .acq_thresh_o (acq_thresh_o),
    .cfg_o        (cfg_o),
    .freq_wr_o    (freq_wr_o),
    .sat_id_o     (sat_id_o)
  );

  int checks = 0;
  int errors = 0;
  int fw_cnt = 0;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[12];

  // freq_wr_o is a one-cycle pulse, so each pulse is seen at exactly one negedge
  always @(negedge wb_clk_i) if (freq_wr_o) fw_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus transaction, started #1 after a posedge; returns ack, data and latency in cycles
  task automatic bus(input logic [31:0] a, input logic we, input logic [31:0] d,
                     input logic [3:0] s, input logic dump,
                     output logic acked, output logic [31:0] rd, output int lat);
    wb_adr_i = a; wb_we_i = we; wb_dat_i = d; wb_sel_i = s;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; dump_i = dump;
    acked = 1'b0; rd = '0; lat = 0;
    while (!acked && lat < 4) begin
      @(posedge wb_clk_i); #1;
      lat++;
      dump_i = 1'b0;
      if (wb_ack_o) begin
        acked = 1'b1;
        rd    = wb_dat_o;
      end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic acked; logic [31:0] rd; int lat;
    bus(a, 1'b1, d, s, 1'b0, acked, rd, lat);
    check($sformatf("write ack @%0h", a), {31'd0, acked}, 32'd1);
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp);
    logic acked; logic [31:0] rd; int lat; sb_t e;
    sb_q.push_back('{adr: a, exp: exp});
    bus(a, 1'b0, 32'h0, 4'hF, 1'b0, acked, rd, lat);
    check($sformatf("read latency @%0h", a), 32'(lat), 32'd1);
    e = sb_q.pop_front();
    check($sformatf("read data @%0h", e.adr), rd, e.exp);
  endtask

  task automatic pulse_dump();
    dump_i = 1'b1;
    @(posedge wb_clk_i); #1;
    dump_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic set_acc(input logic [31:0] ip, input logic [31:0] qp, input logic [31:0] il,
                         input logic [31:0] ql, input logic [31:0] ie, input logic [31:0] qe);
    acc_ip_i = ip; acc_qp_i = qp; acc_il_i = il;
    acc_ql_i = ql; acc_ie_i = ie; acc_qe_i = qe;
  endtask

  initial begin
    logic        acked;
    logic [31:0] rd;
    int          lat;
    logic [3:0]  ack_pat;

    wb_rst_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; dump_i = 1'b0; lock_i = 1'b0;
    set_acc(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("reset ack", {31'd0, wb_ack_o}, 32'd0);
    check("reset dat", wb_dat_o, 32'd0);
    check("reset freq_wr", {31'd0, freq_wr_o}, 32'd0);
    check("reset cfg", cfg_o, 32'd0);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;

    // Every mapped offset reads zero after reset
    for (int i = 0; i <= 12; i++) rd_chk(32'(32'hA00 + 4 * i), 32'h0);

    vecs[0]  = '{adr: 32'hA04, we: 1'b1, dat: 32'h0FB82165, sel: 4'hF, exp: 32'h0};
    vecs[1]  = '{adr: 32'hA00, we: 1'b1, dat: 32'h16EA4A8C, sel: 4'hF, exp: 32'h0};
    vecs[2]  = '{adr: 32'hA10, we: 1'b1, dat: 32'h000003E8, sel: 4'hF, exp: 32'h0};
    vecs[3]  = '{adr: 32'hA14, we: 1'b1, dat: 32'h1409A1BE, sel: 4'hF, exp: 32'h0};
    vecs[4]  = '{adr: 32'hA00, we: 1'b0, dat: 32'h0,        sel: 4'hF, exp: 32'h16EA4A8C};
    vecs[5]  = '{adr: 32'hA04, we: 1'b0, dat: 32'h0,        sel: 4'hF, exp: 32'h0FB82165};
    vecs[6]  = '{adr: 32'hA10, we: 1'b0, dat: 32'h0,        sel: 4'hF, exp: 32'h000003E8};
    vecs[7]  = '{adr: 32'hA14, we: 1'b0, dat: 32'h0,        sel: 4'hF, exp: 32'h1409A1BE};
    vecs[8]  = '{adr: 32'hA08, we: 1'b0, dat: 32'h0,        sel: 4'hF, exp: 32'h0};
    vecs[9]  = '{adr: 32'hA10, we: 1'b1, dat: 32'hFFFFFFFF, sel: 4'h2, exp: 32'h0};
    vecs[10] = '{adr: 32'hA10, we: 1'b0, dat: 32'h0,        sel: 4'hF, exp: 32'h0000FFE8};
    vecs[11] = '{adr: 32'hA13, we: 1'b0, dat: 32'h0,        sel: 4'hF, exp: 32'h0000FFE8};

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) wr(vecs[i].adr, vecs[i].dat, vecs[i].sel);
      else rd_chk(vecs[i].adr, vecs[i].exp);
    end

    check("freq_wr pulses", 32'(fw_cnt), 32'd2);
    check("sat_id", {24'd0, sat_id_o}, 32'h14);
    check("code_freq_o", code_freq_o, 32'h16EA4A8C);
    check("carr_freq_o", carr_freq_o, 32'h0FB82165);
    check("acq_thresh_o", acq_thresh_o, 32'h0000FFE8);
    check("cfg_o", cfg_o, 32'h1409A1BE);

    // First dump captures
    set_acc(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
    pulse_dump();
    rd_chk(32'hA30, 32'h1);
    for (int i = 0; i < 6; i++) rd_chk(32'(32'hA18 + 4 * i), 32'(32'h11 * (i + 1)));
    wr(32'hA30, 32'h0, 4'hF);
    rd_chk(32'hA30, 32'h0);

    // Dump while full holds data and flags overrun
    pulse_dump();
    rd_chk(32'hA30, 32'h1);
    set_acc(32'h99, 32'h99, 32'h99, 32'h99, 32'h99, 32'h99);
    pulse_dump();
    rd_chk(32'hA18, 32'h11);
    rd_chk(32'hA2C, 32'h66);
    rd_chk(32'hA30, 32'h3);
    lock_i = 1'b1;
    rd_chk(32'hA30, 32'h7);
    lock_i = 1'b0;
    wr(32'hA30, 32'h0, 4'hE);
    rd_chk(32'hA30, 32'h3);
    wr(32'hA30, 32'h3, 4'hF);
    rd_chk(32'hA30, 32'h3);
    wr(32'hA30, 32'h0, 4'hF);
    rd_chk(32'hA30, 32'h0);

    // Clear and dump on the same edge: recapture with new data
    set_acc(32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66);
    pulse_dump();
    set_acc(32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6);
    bus(32'hA30, 1'b1, 32'h0, 4'hF, 1'b1, acked, rd, lat);
    check("clr+dump ack", {31'd0, acked}, 32'd1);
    rd_chk(32'hA30, 32'h1);
    rd_chk(32'hA18, 32'hA1);
    rd_chk(32'hA2C, 32'hA6);

    // Overrun set, then clear only ready together with a dump: overrun stays
    pulse_dump();
    rd_chk(32'hA30, 32'h3);
    set_acc(32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6);
    bus(32'hA30, 1'b1, 32'h2, 4'hF, 1'b1, acked, rd, lat);
    rd_chk(32'hA30, 32'h3);
    rd_chk(32'hA18, 32'hB1);
    rd_chk(32'hA24, 32'hB4);

    // Out-of-page access gets no ack; read-only write is acked and ignored
    bus(32'hB00, 1'b0, 32'h0, 4'hF, 1'b0, acked, rd, lat);
    check("no ack @B00 read", {31'd0, acked}, 32'd0);
    bus(32'hB00, 1'b1, 32'hDEAD, 4'hF, 1'b0, acked, rd, lat);
    check("no ack @B00 write", {31'd0, acked}, 32'd0);
    wr(32'hA18, 32'h0000DEAD, 4'hF);
    rd_chk(32'hA18, 32'hB1);
    rd_chk(32'hA34, 32'h0);
    rd_chk(32'hAFC, 32'h0);

    // Held strobe acks every second cycle
    wb_adr_i = 32'hA00; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      @(posedge wb_clk_i); #1;
      ack_pat[i] = wb_ack_o;
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("held stb ack pattern", {28'd0, ack_pat}, 32'hA);

    // Reset during a write: no ack, write lost, everything cleared
    wb_adr_i = 32'hA04; wb_we_i = 1'b1; wb_dat_i = 32'hCAFE0001; wb_sel_i = 4'hF;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("mid-reset ack", {31'd0, wb_ack_o}, 32'd0);
    check("mid-reset carr_freq", carr_freq_o, 32'h0);
    check("mid-reset code_freq", code_freq_o, 32'h0);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    rd_chk(32'hA04, 32'h0);
    rd_chk(32'hA30, 32'h0);
    rd_chk(32'hA18, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_channel_wb_slave.md
Name: gps_channel_wb_slave

Overview:
Wishbone classic slave that exposes the control and observation register file of one GPS tracking channel. It is the responder end of the bus that firmware and the bench master drive. It holds the NCO frequency, offset, threshold and configuration words, and snapshots the six correlator accumulators on each dump. It also provides the ready/overrun status handshake that software polls and clears.

Parameters:
BASE_ADDR, 32'h00000A00, channel base; decoded on adr[31:8]
AW, 32, address width
DW, 32, data width (fixed at 32; sel is 4 bits)

Ports:
wb_clk_i  in  1  single clock for bus and register logic
wb_rst_i  in  1  reset, synchronous, active-low
wb_adr_i  in  AW  byte address
wb_dat_i  in  DW  write data
wb_sel_i  in  4  byte enables for writes
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_dat_o  out  DW  read data, valid with ack
wb_ack_o  out  1  acknowledge
dump_i  in  1  one-cycle accumulator dump pulse, already synchronous to wb_clk_i
acc_ip_i, acc_qp_i, acc_ie_i, acc_qe_i, acc_il_i, acc_ql_i  in  32 each  live accumulator values
lock_i  in  1  code/carrier lock indication, read-only in status
code_freq_o, carr_freq_o, code_off_o, carr_off_o, acq_thresh_o, cfg_o  out  32 each  register contents
freq_wr_o  out  1  one-cycle pulse after any write to 0x00–0x0C
sat_id_o  out  8  cfg[31:24]

Behaviour:
- Reset (wb_rst_i==0 at a clock edge): all registers, snapshots, status, wb_ack_o, wb_dat_o, and freq_wr_o are 0.
- Select is stb & cyc & (adr[31:8]==BASE_ADDR[31:8]) & !wb_ack_o. Offset is adr[7:2]; adr[1:0] is ignored.
- Ack is registered: it asserts exactly one cycle after select and lasts one cycle. Holding stb produces an ack every second cycle.
- Read data is registered in the same edge as ack. It reflects register state before any same-edge update.
- Writes commit on the select edge, per byte under wb_sel_i. Writes to read-only offsets are acked and ignored.
- Offsets 0x00 through 0x14 are read/write: CODE_FREQ, CARR_FREQ, CODE_OFF, CARR_OFF, ACQ_THRESH, CONFIG.
- Offsets 0x18 through 0x2C are read-only snapshots, in order: IP, QP, IL, QL, IE, QE.
- Offset 0x30 is STATUS:
  - bit0 ready;
  - bit1 overrun;
  - bit2 lock_i (live);
  - other bits read 0.
- STATUS write semantics: writing 0 to bit0 clears ready, and writing 0 to bit1 clears overrun. Writing 1 leaves the bit unchanged. This requires sel[0]=1.
- Unmapped offsets inside the base page read 0 and are acked. Addresses outside the page get no ack.
- Snapshot FSM has two states, EMPTY and FULL, and ready equals FULL.
  - EMPTY + dump_i: all six snapshots capture the acc_*_i values, and the FSM goes to FULL.
  - FULL + dump_i: snapshots are held (not overwritten), overrun is set sticky, and the FSM stays FULL.
  - FULL + status write clearing bit0: the FSM goes to EMPTY.
  - A clear and dump_i in the same edge: the clear applies first, then the capture. Result is FULL with the new data and overrun unchanged.
- freq_wr_o pulses the cycle after the write edge. It is combined across the four frequency/offset registers.
- Reset asserted mid-transaction: ack is dropped immediately and a pending write is lost. The master must restart the cycle.

Decomposition:
- Shared package gps_wb_pkg holds:
  - offset constants REG_CODE_FREQ=0x00 through REG_STATUS=0x30;
  - status bit indices ST_READY=0, ST_OVR=1, ST_LOCK=2;
  - the config field slice for SAT_ID.
- One sub-module, gps_acc_snapshot: the EMPTY/FULL FSM, the six 32-bit shadow registers, and the overrun flag. Its inputs are dump_i, clr_ready and clr_ovr.

Test Plan:
- Reset then read all offsets 0x00–0x30 -> every read returns 0, with ack one cycle after stb each time.
- Write 0x0FB82165 to 0xA04, 0x16EA4A8C to 0xA00, 0x000003E8 to 0xA10, 0x1409A1BE to 0xA14 -> read-back matches, sat_id_o=0x14, freq_wr_o pulses twice.
- Write 0xFFFFFFFF to 0xA10 with sel=4'b0010 after 0x3E8 -> reads 0x0000FFE8.
- Drive acc_ip_i=0x11, acc_qp_i=0x22, acc_il_i=0x33, acc_ql_i=0x44, acc_ie_i=0x55, acc_qe_i=0x66 and pulse dump_i:
  - STATUS reads 0x1;
  - 0xA18–0xA2C read 0x11, 0x22, 0x33, 0x44, 0x55, 0x66;
  - writing STATUS 0x0 then reading gives 0x0.
- With ready set, change the inputs to 0x99 and pulse dump_i -> snapshots stay 0x11… and STATUS reads 0x3. Writing 0x0 clears both bits.
- Status clear and dump_i in the same cycle -> STATUS reads 0x1 with the new values. Access to 0xB00 gets no ack; write to 0xA18 is acked and the value is unchanged.
